// File: rtl/synth_fp_pkg.sv
// -----------------------------------------------------------------------------
// synth_fp_pkg
//   Shared definitions for the synth float32 datapath blocks.
//   - FP_ZERO / FP_ONE : float32 bit patterns used as constants.
//   - mix_state_e      : state encoding of the voice mixer sequencer.
// -----------------------------------------------------------------------------
package synth_fp_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_TAKE  = 3'd3,
    ST_ADD_GO   = 3'd4,
    ST_ADD_WAIT = 3'd5,
    ST_OUT      = 3'd6
  } mix_state_e;

endpackage

// File: rtl/fp_voice_mixer.sv
// -----------------------------------------------------------------------------
// fp_voice_mixer
//   Sums the float32 samples of all active synth voices into one mixed sample
//   per frame. Voices are visited in ascending index order; each active
//   sample is fetched from a synchronous voice RAM and folded into a running
//   sum by an external fpadd. This block performs no float arithmetic: the
//   first active sample is taken verbatim, later ones go through fpadd.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high
//   start       begin a frame (sampled only when idle)
//   voice_mask  active voice slots, latched when start is accepted
//   rd_addr     voice RAM read address (registered)
//   rd_data     voice RAM sample, valid one cycle after rd_addr
//   add_start   one-cycle operand strobe, wired to fpadd reset
//   add_a       fpadd dataa (running sum)
//   add_b       fpadd datab (new sample)
//   add_result  fpadd result
//   add_done    fpadd done
//   mix_out     mixed sample, held until the next frame completes
//   mix_valid   one-cycle pulse when mix_out updates
//   busy        high from accepted start until return to idle
//   err         sticky adder timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module fp_voice_mixer
  import synth_fp_pkg::*;
#(
  parameter int NVOICE      = 8,
  parameter int ADDR_W      = 3,
  parameter int ADD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NVOICE-1:0] voice_mask,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              add_start,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic [31:0]       add_result,
  input  logic              add_done,
  output logic [31:0]       mix_out,
  output logic              mix_valid,
  output logic              busy,
  output logic              err
);

  localparam int TMO_W = (ADD_TIMEOUT < 2) ? 1 : $clog2(ADD_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NVOICE - 1);
  // Last ADD_WAIT cycle before giving up on the adder: the wait lasts
  // exactly ADD_TIMEOUT cycles.
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ADD_TIMEOUT - 1);

  mix_state_e        state;
  logic [NVOICE-1:0] mask;
  logic [ADDR_W-1:0] idx;
  logic              first;
  logic [31:0]       acc;
  logic [TMO_W-1:0]  tmo;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mask      <= '0;
      idx       <= '0;
      first     <= 1'b0;
      acc       <= FP_ZERO;
      tmo       <= '0;
      rd_addr   <= '0;
      add_start <= 1'b0;
      add_a     <= FP_ZERO;
      add_b     <= FP_ZERO;
      mix_out   <= FP_ZERO;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so that any state raising them
      // produces exactly one cycle; all state uses non-blocking assignments.
      add_start <= 1'b0;
      mix_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            mask  <= voice_mask;
            idx   <= '0;
            first <= 1'b1;
            busy  <= 1'b1;
            state <= ST_SCAN;
          end
        end

        // One voice slot per cycle; inactive slots are skipped in place.
        ST_SCAN: begin
          if (mask[idx]) begin
            rd_addr <= idx;
            state   <= ST_RD_WAIT;
          end else if (idx == LAST_IDX) begin
            state <= ST_OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // The RAM registers rd_addr; data appears one cycle later.
        ST_RD_WAIT: begin
          state <= ST_RD_TAKE;
        end

        ST_RD_TAKE: begin
          if (first) begin
            // First active voice seeds the sum verbatim, no add needed.
            acc   <= rd_data;
            first <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= ST_OUT;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SCAN;
            end
          end else begin
            // Operands are registered together with the strobe so they are
            // already stable while add_start is high in ADD_GO, and stay put
            // until the next RD_TAKE.
            add_a     <= acc;
            add_b     <= rd_data;
            add_start <= 1'b1;
            state     <= ST_ADD_GO;
          end
        end

        ST_ADD_GO: begin
          tmo   <= '0;
          state <= ST_ADD_WAIT;
        end

        // tmo == 0 is the cycle right after the strobe; add_done there may
        // still reflect the previous operation, so it is not trusted.
        ST_ADD_WAIT: begin
          if ((tmo != '0) && add_done) begin
            acc <= add_result;
            if (idx == LAST_IDX) begin
              state <= ST_OUT;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_SCAN;
            end
          end else if (tmo == TMO_LAST) begin
            // Abort the frame: mix_out keeps the previous frame's value.
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        ST_OUT: begin
          // first still set means no voice was active in this frame.
          mix_out   <= first ? FP_ZERO : acc;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
